m_div_unit: RTL and testbench
=============================

# m_div_unit

Parametrised, self-sequencing restoring divider for the M-extension unit. It executes DIV, DIVU, REM and REMU on WIDTH-bit operands. It owns its remainder, divisor and quotient registers together with the iteration FSM, so the M-unit top level only issues a start pulse and waits for a one-cycle result strobe. It sits beside the multiplier in the M-unit, fed from the decode-stage operand registers.

## Interface
- WIDTH, 32, operand and result width in bits; any value ≥ 4.
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start_i  in  1  start pulse; accepted only when busy_o=0.
- op_i  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU. Sampled with start_i.
- rs1_i  in  WIDTH  dividend; sampled with start_i.
- rs2_i  in  WIDTH  divisor; sampled with start_i.
- abort_i  in  1  pipeline flush; cancels any operation in flight.
- busy_o  out  1  high in CALC state.
- valid_o  out  1  one-cycle strobe; result_o is valid in this cycle.
- result_o  out  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accepted start.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE or DONE with start_i=1 and abort_i=0:
  - Latch op_i.
  - Signed ops take magnitudes of both operands. Unsigned ops use the raw operands.
  - Load R=|rs1|, D={|rs2|, (WIDTH-1) zeros} (2·WIDTH-1 bits), Z=0, cnt=WIDTH-1.
  - Record neg_q = sign(rs1) XOR sign(rs2) and neg_r = sign(rs1), for signed ops only.
  - Go to CALC.
- CALC, each cycle:
  - Compute sub = {0,R} − D at 2·WIDTH bits.
  - If sub ≥ 0: R ← sub[WIDTH-1:0], Z ← {Z[WIDTH-2:0],1}. Otherwise: R held, Z ← {Z[WIDTH-2:0],0}.
  - D ← D>>1, cnt ← cnt−1.
  - When cnt=0, go to DONE.
- Exit from CALC to DONE:
  - Register result_o = neg_q ? −Z : Z for quotient ops, or neg_r ? −R : R for remainder ops.
  - Sign correction for the quotient is suppressed when the divisor is zero.
- DONE: valid_o=1 for exactly one cycle. Next state is IDLE, or CALC if a new start is accepted.
- Divide by zero: quotient = all ones, remainder = rs1. This holds for signed and unsigned ops.
- Signed overflow (rs1 = −2^(WIDTH-1), rs2 = −1): quotient = −2^(WIDTH-1), remainder = 0. The unsigned path produces this naturally.
- abort_i=1 in any state:
  - Next state is IDLE; valid_o is not asserted.
  - result_o holds its previous value.
  - abort_i takes priority over a simultaneous start_i.
- start_i while busy_o=1 is ignored; no queuing.
- Reset mid-operation: all state cleared immediately; no valid_o.

## Timing
- Reset values: busy_o=0, valid_o=0, result_o=0. R, D, Z and cnt are 0.
- Latency, normal path:
  - start_i is sampled at edge 0.
  - CALC occupies cycles 1..WIDTH.
  - valid_o is high in cycle WIDTH+1. For WIDTH=32, that is 33 cycles from start to valid.
- Throughput: a start accepted in the DONE cycle enters CALC the next cycle. Back-to-back issue rate is WIDTH+1 cycles.
- busy_o is registered; it is high exactly in the WIDTH CALC cycles.
- result_o is registered and changes only on the edge entering DONE.

## Configuration
- M_DIV_FASTPATH_EN, defined:
  - Divide-by-zero and signed overflow skip CALC. The FSM goes IDLE → DONE directly, so valid_o is high in cycle 1 after start.
  - Divide-by-zero results: quotient = all ones, remainder = rs1.
  - Signed overflow results: quotient = −2^(WIDTH-1), remainder = 0.
- M_DIV_FASTPATH_EN, undefined:
  - These cases run the full WIDTH iterations.
  - Results are identical to the defined case; only latency differs (WIDTH+1 cycles).

## Test plan
- DIVU, WIDTH=32, rs1=100, rs2=7 -> valid_o in cycle 33, result_o=14. REMU with the same operands -> 2.
- DIV, rs1=−7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD (−3). REM with the same operands -> 0xFFFFFFFF (−1).
- DIV/REM, rs1=5, rs2=0 -> 0xFFFFFFFF and 5. Latency is 1 cycle with M_DIV_FASTPATH_EN, 33 without.
- DIV, rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- abort_i in cycle 10 of a DIVU -> IDLE in cycle 11, no valid_o, result_o unchanged. Next start completes normally.
- WIDTH=8 build, DIVU 200/3 -> 66 in cycle 9. start_i asserted during busy -> ignored. Start issued in the DONE cycle -> accepted.

Source files
------------

// File: rtl/m_div_unit.sv
// m_div_unit: self-sequencing restoring divider for the M-extension unit.
// Executes DIV, DIVU, REM and REMU on WIDTH-bit operands, one quotient bit
// per cycle, and strobes valid_o for one cycle when the result is ready.
// Optional build macro: M_DIV_FASTPATH_EN -- when defined, divide-by-zero and
// signed overflow bypass the iteration and complete in a single cycle.
module m_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic               busy_q;
    logic               valid_q;
    logic [WIDTH-1:0]   r_q;
    logic [2*WIDTH-2:0] d_q;
    logic [WIDTH-1:0]   z_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rem_op_q;
    logic               neg_q_q;
    logic               neg_r_q;
    logic               div_zero_q;

    logic               is_signed_in;
    logic               rs1_neg;
    logic               rs2_neg;
    logic [WIDTH-1:0]   rs1_mag;
    logic [WIDTH-1:0]   rs2_mag;
    logic               start_ok;
    logic               sub_ok;
    logic [WIDTH-1:0]   r_next;
    logic [WIDTH-1:0]   z_next;
    logic [WIDTH-1:0]   calc_result;
    logic               fast_hit;

    // Operand preparation: signed ops divide magnitudes, signs are fixed up at the end
    always_comb begin
        is_signed_in = ~op_i[0];
        rs1_neg      = is_signed_in & rs1_i[WIDTH-1];
        rs2_neg      = is_signed_in & rs2_i[WIDTH-1];
        rs1_mag      = rs1_neg ? (~rs1_i + 1'b1) : rs1_i;
        rs2_mag      = rs2_neg ? (~rs2_i + 1'b1) : rs2_i;
        start_ok     = start_i & ~abort_i & ((state_q == S_IDLE) | (state_q == S_DONE));
    end

    // One restoring step: subtract the shifted divisor if it fits in the partial remainder
    always_comb begin
        sub_ok = ({{WIDTH{1'b0}}, r_q} >= {1'b0, d_q});
        r_next = sub_ok ? (r_q - d_q[WIDTH-1:0]) : r_q;
        z_next = {z_q[WIDTH-2:0], sub_ok};
        if (rem_op_q) begin
            calc_result = neg_r_q ? (~r_next + 1'b1) : r_next;
        end else begin
            calc_result = (neg_q_q & ~div_zero_q) ? (~z_next + 1'b1) : z_next;
        end
    end

`ifdef M_DIV_FASTPATH_EN
    logic             fast_zero;
    logic             fast_ovf;
    logic [WIDTH-1:0] fast_result;

    // Detect the two corner cases whose results are known without iterating
    always_comb begin
        fast_zero = (rs2_i == '0);
        fast_ovf  = is_signed_in & (rs1_i == {1'b1, {(WIDTH-1){1'b0}}}) & (rs2_i == '1);
        fast_hit  = fast_zero | fast_ovf;
        if (op_i[1]) begin
            fast_result = fast_zero ? rs1_i : '0;
        end else begin
            fast_result = fast_zero ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign fast_hit = 1'b0;
`endif

    // Next-state logic: abort wins over everything, DONE can accept a new start directly
    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_d = fast_hit ? S_DONE : S_CALC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register with registered busy/valid flags derived from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == S_CALC);
            valid_q <= (state_d == S_DONE);
        end
    end

    // Datapath registers: load on an accepted start, iterate while calculating
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q        <= '0;
            d_q        <= '0;
            z_q        <= '0;
            cnt_q      <= '0;
            rem_op_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (start_ok) begin
            r_q        <= rs1_mag;
            d_q        <= {rs2_mag, {(WIDTH-1){1'b0}}};
            z_q        <= '0;
            cnt_q      <= CNT_W'(WIDTH - 1);
            rem_op_q   <= op_i[1];
            neg_q_q    <= rs1_neg ^ rs2_neg;
            neg_r_q    <= rs1_neg;
            div_zero_q <= (rs2_i == '0);
        end else if ((state_q == S_CALC) && !abort_i) begin
            r_q   <= r_next;
            d_q   <= d_q >> 1;
            z_q   <= z_next;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Result register: written only on the edge that enters DONE, otherwise held
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_o <= '0;
        end else if (!abort_i) begin
            if ((state_q == S_CALC) && (cnt_q == '0)) begin
                result_o <= calc_result;
            end
`ifdef M_DIV_FASTPATH_EN
            else if (start_ok && fast_hit) begin
                result_o <= fast_result;
            end
`endif
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_m_div_unit.sv
// tb_m_div_unit: randomized self-checking bench for m_div_unit.
// Results are predicted with plain integer arithmetic; a 32-bit and an 8-bit
// instance share one clock.
module tb_m_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic        abort_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    logic        start8;
    logic        abort8;
    logic [1:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        valid8;
    logic [7:0]  res8;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    m_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .abort_i(abort_i),
        .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
    );

    m_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .resetn(resetn), .start_i(start8), .op_i(op8),
        .rs1_i(a8), .rs2_i(b8), .abort_i(abort8),
        .busy_o(busy8), .valid_o(valid8), .result_o(res8)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: RISC-V division semantics at width w using 64-bit integers
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
        longint ua, ub, sa, sb, q, r;
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        ua = longint'(a & mask);
        ub = longint'(b & mask);
        sa = ua[w-1] ? (ua - (64'sd1 <<< w)) : ua;
        sb = ub[w-1] ? (ub - (64'sd1 <<< w)) : ub;
        if (ub == 0) begin
            q = longint'(mask);
            r = ua;
        end else if (op[0] == 1'b0) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        return (op[1] ? 32'(r) : 32'(q)) & mask;
    endfunction

    // Expected cycles from start to valid for the 32-bit instance
    function automatic int expLatency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef M_DIV_FASTPATH_EN
        if ((b == 32'h0) || (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))) return 1;
        return 33;
`else
        return (op == 2'b00 && a == b) ? 33 : 33;
`endif
    endfunction

    // Issue one operation to the 32-bit divider and check latency, result and strobe width
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input string tag);
        int cyc;
        int exp_lat;
        logic [31:0] exp;
        exp     = model(op, a, b, 32);
        exp_lat = expLatency(op, a, b);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        rs1_i   = $urandom;
        rs2_i   = $urandom;
        op_i    = 2'($urandom_range(0, 3));
        cyc     = 1;
        checkOutput({tag, " busy"}, {31'b0, busy_o}, (exp_lat > 1) ? 32'd1 : 32'd0);
        while (!valid_o && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, " latency"}, cyc, exp_lat);
        checkOutput({tag, " result"}, result_o, exp);
        @(posedge clk);
        #1;
        checkOutput({tag, " strobe"}, {31'b0, valid_o}, 32'd0);
        checkOutput({tag, " hold"}, result_o, exp);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int seen;
        logic [1:0]  op;
        logic [31:0] a, b, prev;

        resetn  = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        op_i    = 2'b00;
        rs1_i   = '0;
        rs2_i   = '0;
        start8  = 1'b0;
        abort8  = 1'b0;
        op8     = 2'b00;
        a8      = '0;
        b8      = '0;

        #12;
        checkOutput("reset busy",    {31'b0, busy_o},  32'd0);
        checkOutput("reset valid",   {31'b0, valid_o}, 32'd0);
        checkOutput("reset result",  result_o,         32'd0);
        checkOutput("reset8 result", {24'b0, res8},    32'd0);
        @(negedge clk);
        resetn = 1'b1;

        applyStimulus(2'b01, 32'd100, 32'd7, "divu 100/7");
        applyStimulus(2'b11, 32'd100, 32'd7, "remu 100/7");
        applyStimulus(2'b00, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, "rem -7/2");
        applyStimulus(2'b00, 32'd5, 32'd0, "div 5/0");
        applyStimulus(2'b10, 32'd5, 32'd0, "rem 5/0");
        applyStimulus(2'b10, 32'hFFFF_FFFB, 32'd0, "rem -5/0");
        applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");
        applyStimulus(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu big");

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                4: a = $urandom_range(0, 100);
                default: ;
            endcase
            applyStimulus(op, a, b, $sformatf("rand%0d", i));
        end

        prev = result_o;
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 2'b01;
        rs1_i   = 32'd1_000_000;
        rs2_i   = 32'd3;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        cyc = 1;
        repeat (9) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("abort busy before", {31'b0, busy_o}, 32'd1);
        abort_i = 1'b1;
        @(posedge clk);
        #1;
        abort_i = 1'b0;
        checkOutput("abort busy after",  {31'b0, busy_o},  32'd0);
        checkOutput("abort valid after", {31'b0, valid_o}, 32'd0);
        checkOutput("abort result held", result_o, prev);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_o) seen++;
        end
        checkOutput("abort no strobe", seen, 0);
        applyStimulus(2'b01, 32'd1_000_000, 32'd3, "post-abort");

        @(negedge clk);
        start8 = 1'b1;
        op8    = 2'b01;
        a8     = 8'd200;
        b8     = 8'd3;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        cyc = 1;
        while (cyc < 3) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        start8 = 1'b1;
        op8    = 2'b00;
        a8     = 8'd10;
        b8     = 8'd1;
        @(posedge clk);
        #1;
        cyc++;
        start8 = 1'b0;
        while (!valid8 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("w8 divu latency", cyc, 9);
        checkOutput("w8 divu result", {24'b0, res8}, model(2'b01, 32'd200, 32'd3, 8));
        start8 = 1'b1;
        op8    = 2'b11;
        a8     = 8'd200;
        b8     = 8'd3;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        cyc = 1;
        checkOutput("w8 done-start busy", {31'b0, busy8}, 32'd1);
        while (!valid8 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("w8 remu latency", cyc, 9);
        checkOutput("w8 remu result", {24'b0, res8}, model(2'b11, 32'd200, 32'd3, 8));

        @(negedge clk);
        start_i = 1'b1;
        op_i    = 2'b00;
        rs1_i   = 32'd12345;
        rs2_i   = 32'd11;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midreset busy",   {31'b0, busy_o},  32'd0);
        checkOutput("midreset valid",  {31'b0, valid_o}, 32'd0);
        checkOutput("midreset result", result_o,         32'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid_o) seen++;
        end
        checkOutput("midreset no strobe", seen, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
